// File: rtl/aes_encrypt.sv
// Iterative AES-128 encryption core: one round per clock, round keys expanded on the fly.
// Byte 0 of every 128-bit word is [127:120]; state is column-major.

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] z);
    logic [7:0] p, q;
    p = '0;
    q = x;
    for (int i = 0; i < 8; i++) begin
      if (z[i]) p = p ^ q;
      q = {q[6:0], 1'b0} ^ (q[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] x2, x3, x12, x15, x240, inv;

  // multiplicative inverse as a^254 (maps 0 to 0), then the FIPS-197 affine map
  always_comb begin
    x2   = gmul(a, a);
    x3   = gmul(x2, a);
    x12  = gmul(gmul(x3, x3), gmul(x3, x3));
    x15  = gmul(x12, x3);
    x240 = gmul(x15, x15);
    x240 = gmul(x240, x240);
    x240 = gmul(x240, x240);
    x240 = gmul(x240, x240);
    inv  = gmul(gmul(x240, x12), x2);
    y    = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end
endmodule

module aes_encrypt (
  input  logic         clk,
  input  logic         rest,
  input  logic         start,
  input  logic [127:0] plain_text,
  input  logic [127:0] local_key,
  output logic [127:0] cipher_text,
  output logic         done,
  output logic         ack,
  output logic         busy
);
  typedef enum logic {IDLE, RUN} fsm_t;

  fsm_t         fsm, fsm_nxt;
  logic [127:0] st, rk, nk, sb_out, sr, mc;
  logic [31:0]  rot, kw_sub, kt;
  logic [3:0]   rnd;
  logic [7:0]   rcon;
  logic         start_q, accept, last;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  for (genvar i = 0; i < 16; i++) begin : g_sb
    aes_sbox u_sb (.a(st[127-8*i -: 8]), .y(sb_out[127-8*i -: 8]));
  end

  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sr[127-8*(r+4*c) -: 8] = sb_out[127-8*(r+4*((c+r)%4)) -: 8];
    end
    assign a0 = sr[127-32*c -: 8];
    assign a1 = sr[119-32*c -: 8];
    assign a2 = sr[111-32*c -: 8];
    assign a3 = sr[103-32*c -: 8];
    assign mc[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                                 a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                 a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                                 xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  end

  // key schedule: SubWord(RotWord(w3)) ^ rcon, chained through w0..w3
  assign rot = {rk[23:0], rk[31:24]};
  for (genvar k = 0; k < 4; k++) begin : g_ksb
    aes_sbox u_ksb (.a(rot[31-8*k -: 8]), .y(kw_sub[31-8*k -: 8]));
  end

  always_comb begin
    case (rnd)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign kt          = kw_sub ^ {rcon, 24'h0};
  assign nk[127:96]  = rk[127:96] ^ kt;
  assign nk[95:64]   = rk[95:64]  ^ nk[127:96];
  assign nk[63:32]   = rk[63:32]  ^ nk[95:64];
  assign nk[31:0]    = rk[31:0]   ^ nk[63:32];

  always_comb begin
    fsm_nxt = fsm;
    accept  = 1'b0;
    last    = 1'b0;
    case (fsm)
      IDLE: if (start && !start_q) begin
        accept  = 1'b1;
        fsm_nxt = RUN;
      end
      RUN: if (rnd == 4'd10) begin
        last    = 1'b1;
        fsm_nxt = IDLE;
      end
      default: fsm_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) fsm <= IDLE;
    else       fsm <= fsm_nxt;
  end

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      st          <= '0;
      rk          <= '0;
      rnd         <= '0;
      start_q     <= 1'b0;
      cipher_text <= '0;
      done        <= 1'b0;
      ack         <= 1'b0;
      busy        <= 1'b0;
    end else begin
      start_q <= start;
      ack     <= 1'b0;
      done    <= 1'b0;
      if (accept) begin
        st   <= plain_text ^ local_key;
        rk   <= local_key;
        rnd  <= 4'd1;
        ack  <= 1'b1;
        busy <= 1'b1;
      end else if (fsm == RUN) begin
        if (last) begin
          cipher_text <= sr ^ nk;
          done        <= 1'b1;
          busy        <= 1'b0;
        end else begin
          st  <= mc ^ nk;
          rk  <= nk;
          rnd <= rnd + 4'd1;
        end
      end
    end
  end
endmodule
